// File: rtl/fc_pkg.sv
// Shared types for the transmit flow-control credit gate.
// Optional feature macro: FC_TX_INFINITE_CREDIT_EN.
package fc_pkg;

    typedef enum logic [1:0] {
        P   = 2'b00,
        NP  = 2'b01,
        CPL = 2'b10
    } fc_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FC_INIT = 2'b01,
        ACTIVE  = 2'b10
    } fc_state_t;

    localparam int FC_HDR_W  = 8;
    localparam int FC_DATA_W = 12;

    // One-hot class select {CPL, NP, P}; the reserved code selects nothing.
    function automatic logic [2:0] cls_dec(input logic [1:0] t);
        logic [2:0] s;
        s = 3'b000;
        case (t)
            P:       s = 3'b001;
            NP:      s = 3'b010;
            CPL:     s = 3'b100;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fc_credit_check.sv
// One credit limit / credits consumed pair with its modular check.
// FC_TX_INFINITE_CREDIT_EN adds an infinite flag set by a zero InitFC.
module fc_credit_check #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_we,
    input  logic         upd_we,
    input  logic [W-1:0] cl_wdata,
    input  logic         cc_we,
    input  logic [W-1:0] cc_add,
    input  logic [W-1:0] need,
    output logic         ok,
    output logic [W-1:0] avail
);

    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] cl_q;
    logic [W-1:0] cc_q;
    logic [W-1:0] room;
    logic         inf_q;
    logic         cl_en;
    logic         cc_en;

`ifdef FC_TX_INFINITE_CREDIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inf_q <= 1'b0;
        end else if (init_we) begin
            inf_q <= (cl_wdata == '0);
        end
    end

    // An infinite kind keeps its limit frozen and never counts usage.
    assign cl_en = init_we || (upd_we && !inf_q);
    assign cc_en = cc_we && !inf_q;
`else
    assign inf_q = 1'b0;
    assign cl_en = init_we || upd_we;
    assign cc_en = cc_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cl_q <= '0;
            cc_q <= '0;
        end else begin
            if (cl_en) begin
                cl_q <= cl_wdata;
            end
            if (cc_en) begin
                cc_q <= cc_q + cc_add;
            end
        end
    end

    assign room  = cl_q - (cc_q + need);
    assign ok    = inf_q || (room <= HALF);
    assign avail = inf_q ? '1 : (cl_q - cc_q);

endmodule

// File: rtl/fc_tx_credit_gate.sv
// Transmit-side PCIe credit gate: captures CL from FC DLLPs, tracks CC.
// FC_TX_INFINITE_CREDIT_EN enables zero-advertised infinite credits.
module fc_tx_credit_gate
    import fc_pkg::*;
#(
    parameter int HDR_W  = FC_HDR_W,
    parameter int DATA_W = FC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fc_valid_i,
    input  logic              fc_is_init_i,
    input  logic [1:0]        fc_type_i,
    input  logic [HDR_W-1:0]  fc_hdr_i,
    input  logic [DATA_W-1:0] fc_data_i,
    input  logic              tlp_valid_i,
    input  logic [1:0]        tlp_type_i,
    input  logic [DATA_W-1:0] tlp_data_cred_i,
    output logic              tlp_ready_o,
    output logic              init_done_o,
    output logic [HDR_W-1:0]  avail_hdr_o,
    output logic [DATA_W-1:0] avail_data_o
);

    localparam logic [HDR_W-1:0] ONE_H = HDR_W'(1);

    fc_state_t  state_q;
    fc_state_t  state_d;
    logic [2:0] mask_q;
    logic [2:0] mask_d;

    logic       active;
    logic       init_wr;
    logic       upd_wr;
    logic       accept;
    logic [2:0] fc_sel;
    logic [2:0] init_sel;
    logic [2:0] upd_sel;
    logic [2:0] acc_sel;

    logic [2:0]        hdr_ok;
    logic [HDR_W-1:0]  hdr_av [3];
    logic              dp_ok;
    logic              dc_ok;
    logic [DATA_W-1:0] dp_av;
    logic [DATA_W-1:0] dc_av;
    logic              hdr_pass;
    logic              data_pass;

    assign active  = (state_q == ACTIVE);
    assign fc_sel  = fc_valid_i ? cls_dec(fc_type_i) : 3'b000;
    assign init_wr = fc_is_init_i && !active;
    assign upd_wr  = !fc_is_init_i && active;

    assign init_sel = init_wr ? fc_sel : 3'b000;
    assign upd_sel  = upd_wr ? fc_sel : 3'b000;
    assign accept   = tlp_valid_i && tlp_ready_o;
    assign acc_sel  = accept ? cls_dec(tlp_type_i) : 3'b000;

    assign mask_d = mask_q | init_sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|init_sel) begin
                    state_d = (mask_d == 3'b111) ? ACTIVE : FC_INIT;
                end
            end
            FC_INIT: begin
                if (mask_d == 3'b111) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE:  state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    fc_credit_check #(.W(HDR_W)) u_p_hdr (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_sel[0]),
        .upd_we   (upd_sel[0]),
        .cl_wdata (fc_hdr_i),
        .cc_we    (acc_sel[0]),
        .cc_add   (ONE_H),
        .need     (ONE_H),
        .ok       (hdr_ok[0]),
        .avail    (hdr_av[0])
    );

    fc_credit_check #(.W(DATA_W)) u_p_data (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_sel[0]),
        .upd_we   (upd_sel[0]),
        .cl_wdata (fc_data_i),
        .cc_we    (acc_sel[0]),
        .cc_add   (tlp_data_cred_i),
        .need     (tlp_data_cred_i),
        .ok       (dp_ok),
        .avail    (dp_av)
    );

    fc_credit_check #(.W(HDR_W)) u_np_hdr (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_sel[1]),
        .upd_we   (upd_sel[1]),
        .cl_wdata (fc_hdr_i),
        .cc_we    (acc_sel[1]),
        .cc_add   (ONE_H),
        .need     (ONE_H),
        .ok       (hdr_ok[1]),
        .avail    (hdr_av[1])
    );

    fc_credit_check #(.W(HDR_W)) u_cpl_hdr (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_sel[2]),
        .upd_we   (upd_sel[2]),
        .cl_wdata (fc_hdr_i),
        .cc_we    (acc_sel[2]),
        .cc_add   (ONE_H),
        .need     (ONE_H),
        .ok       (hdr_ok[2]),
        .avail    (hdr_av[2])
    );

    fc_credit_check #(.W(DATA_W)) u_cpl_data (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_sel[2]),
        .upd_we   (upd_sel[2]),
        .cl_wdata (fc_data_i),
        .cc_we    (acc_sel[2]),
        .cc_add   (tlp_data_cred_i),
        .need     (tlp_data_cred_i),
        .ok       (dc_ok),
        .avail    (dc_av)
    );

    // NP carries no data credit; the reserved class never passes.
    always_comb begin
        hdr_pass     = 1'b0;
        data_pass    = 1'b0;
        avail_hdr_o  = '0;
        avail_data_o = '0;
        case (tlp_type_i)
            P: begin
                hdr_pass     = hdr_ok[0];
                data_pass    = dp_ok;
                avail_hdr_o  = hdr_av[0];
                avail_data_o = dp_av;
            end
            NP: begin
                hdr_pass    = hdr_ok[1];
                data_pass   = 1'b1;
                avail_hdr_o = hdr_av[1];
            end
            CPL: begin
                hdr_pass     = hdr_ok[2];
                data_pass    = dc_ok;
                avail_hdr_o  = hdr_av[2];
                avail_data_o = dc_av;
            end
            default: begin
                hdr_pass  = 1'b0;
                data_pass = 1'b0;
            end
        endcase
    end

    assign tlp_ready_o = active && hdr_pass && data_pass;
    assign init_done_o = active;

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// Self-checking bench for fc_tx_credit_gate (HDR_W=8, DATA_W=12).
// Honours FC_TX_INFINITE_CREDIT_EN for the infinite-credit scenario.
module tb_fc_tx_credit_gate;

    localparam logic [1:0] TP   = 2'b00;
    localparam logic [1:0] TNP  = 2'b01;
    localparam logic [1:0] TCPL = 2'b10;
    localparam logic [1:0] TBAD = 2'b11;

    typedef struct {
        logic        rst;
        logic        fv;
        logic        fi;
        logic [1:0]  ft;
        logic [7:0]  fh;
        logic [11:0] fd;
        logic        tv;
        logic [1:0]  tt;
        logic [11:0] tc;
        logic        er;
        logic        ed;
        logic [7:0]  eah;
        logic [11:0] ead;
    } vec_t;

    typedef struct {
        int          id;
        logic        er;
        logic        ed;
        logic [7:0]  eah;
        logic [11:0] ead;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fc_valid_i = 1'b0;
    logic        fc_is_init_i = 1'b0;
    logic [1:0]  fc_type_i = 2'b00;
    logic [7:0]  fc_hdr_i = '0;
    logic [11:0] fc_data_i = '0;
    logic        tlp_valid_i = 1'b0;
    logic [1:0]  tlp_type_i = 2'b00;
    logic [11:0] tlp_data_cred_i = '0;
    logic        tlp_ready_o;
    logic        init_done_o;
    logic [7:0]  avail_hdr_o;
    logic [11:0] avail_data_o;

    int   checks = 0;
    int   errors = 0;
    int   vid = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fc_tx_credit_gate #(.HDR_W(8), .DATA_W(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .fc_valid_i      (fc_valid_i),
        .fc_is_init_i    (fc_is_init_i),
        .fc_type_i       (fc_type_i),
        .fc_hdr_i        (fc_hdr_i),
        .fc_data_i       (fc_data_i),
        .tlp_valid_i     (tlp_valid_i),
        .tlp_type_i      (tlp_type_i),
        .tlp_data_cred_i (tlp_data_cred_i),
        .tlp_ready_o     (tlp_ready_o),
        .init_done_o     (init_done_o),
        .avail_hdr_o     (avail_hdr_o),
        .avail_data_o    (avail_data_o)
    );

    function automatic vec_t mk(
        input logic rs, input logic fv, input logic fi,
        input logic [1:0] ft, input logic [7:0] fh,
        input logic [11:0] fd, input logic tv,
        input logic [1:0] tt, input logic [11:0] tc,
        input logic er, input logic ed,
        input logic [7:0] eah, input logic [11:0] ead);
        vec_t v;
        v.rst = rs; v.fv = fv; v.fi = fi; v.ft = ft;
        v.fh = fh; v.fd = fd; v.tv = tv; v.tt = tt;
        v.tc = tc; v.er = er; v.ed = ed;
        v.eah = eah; v.ead = ead;
        return v;
    endfunction

    // Drive one cycle; outputs are checked mid-cycle on the falling edge.
    task automatic run(input vec_t v);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        rst             = v.rst;
        fc_valid_i      = v.fv;
        fc_is_init_i    = v.fi;
        fc_type_i       = v.ft;
        fc_hdr_i        = v.fh;
        fc_data_i       = v.fd;
        tlp_valid_i     = v.tv;
        tlp_type_i      = v.tt;
        tlp_data_cred_i = v.tc;
        e.id = vid; e.er = v.er; e.ed = v.ed;
        e.eah = v.eah; e.ead = v.ead;
        sb.push_back(e);
        vid++;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at vec %0d", vid - 1);
        end else begin
            g = sb.pop_front();
            if (tlp_ready_o !== g.er || init_done_o !== g.ed ||
                avail_hdr_o !== g.eah || avail_data_o !== g.ead) begin
                errors++;
                $display("FAIL vec %0d got r=%0b d=%0b ah=%0h ad=%0h want r=%0b d=%0b ah=%0h ad=%0h",
                         g.id, tlp_ready_o, init_done_o, avail_hdr_o,
                         avail_data_o, g.er, g.ed, g.eah, g.ead);
            end
        end
    endtask

    vec_t vt[17];
    logic [7:0] cc;

    initial begin
        vt[0]  = mk(1, 0,0,TP,  0,  0,   0,TP,  0,  0,0,0,0);
        vt[1]  = mk(0, 1,1,TP,  4,  16,  0,TP,  4,  0,0,0,0);
        vt[2]  = mk(0, 1,1,TNP, 2,  0,   0,TP,  4,  0,0,4,16);
        vt[3]  = mk(0, 1,1,TCPL,8,  32,  0,TNP, 0,  0,0,2,0);
        vt[4]  = mk(0, 0,0,TP,  0,  0,   0,TCPL,32, 1,1,8,32);
        vt[5]  = mk(0, 0,0,TP,  0,  0,   1,TP,  4,  1,1,4,16);
        vt[6]  = mk(0, 0,0,TP,  0,  0,   1,TP,  4,  1,1,3,12);
        vt[7]  = mk(0, 0,0,TP,  0,  0,   1,TP,  4,  1,1,2,8);
        vt[8]  = mk(0, 0,0,TP,  0,  0,   1,TP,  4,  1,1,1,4);
        vt[9]  = mk(0, 1,0,TP,  6,  24,  1,TP,  4,  0,1,0,0);
        vt[10] = mk(0, 0,0,TP,  0,  0,   0,TP,  4,  1,1,2,8);
        vt[11] = mk(0, 1,0,TP,  5,  20,  1,TP,  4,  1,1,2,8);
        vt[12] = mk(0, 0,0,TP,  0,  0,   0,TP,  4,  0,1,0,0);
        vt[13] = mk(0, 0,0,TP,  0,  0,   0,TNP, 0,  1,1,2,0);
        vt[14] = mk(0, 1,0,TBAD,8'hFF,12'hFFF, 1,TBAD,0, 0,1,0,0);
        vt[15] = mk(0, 1,1,TP,  100,100, 0,TCPL,0,  1,1,8,32);
        vt[16] = mk(0, 0,0,TP,  0,  0,   0,TP,  0,  0,1,0,0);

        for (int i = 0; i < 17; i++) begin
            run(vt[i]);
        end

        // Wrap-around: walk P CC_h up to 0xFE, keeping CL_h two ahead.
        cc = 8'd5;
        run(mk(0, 1,0,TP, cc + 8'd2, 20, 0,TP,0, 0,1,0,0));
        while (cc != 8'hFE) begin
            run(mk(0, 1,0,TP, cc + 8'd3, 20, 1,TP,0, 1,1,2,0));
            cc = cc + 8'd1;
        end
        run(mk(0, 1,0,TP, 8'h02, 20, 0,TP,0, 1,1,2,0));
        for (int i = 0; i < 4; i++) begin
            run(mk(0, 0,0,TP,0,0, 1,TP,0, 1,1,8'(4 - i),0));
        end
        run(mk(0, 0,0,TP,0,0, 1,TP,0, 0,1,0,0));

        // Reset and re-init with a zero Cpl advertisement.
        run(mk(1, 0,0,TP,0,0, 0,TP,0, 0,1,0,0));
        run(mk(0, 1,1,TP,4,16, 0,TP,0, 0,0,0,0));
        run(mk(0, 1,1,TNP,2,0, 0,TP,4, 0,0,4,16));
        run(mk(0, 1,1,TCPL,0,0, 0,TCPL,32, 0,0,0,0));
`ifdef FC_TX_INFINITE_CREDIT_EN
        for (int i = 0; i < 1000; i++) begin
            run(mk(0, 0,0,TP,0,0, 1,TCPL,32, 1,1,8'hFF,12'hFFF));
        end
`else
        for (int i = 0; i < 5; i++) begin
            run(mk(0, 0,0,TP,0,0, 1,TCPL,32, 0,1,0,0));
        end
`endif
        run(mk(1, 0,0,TP,0,0, 0,TP,4, 1,1,4,16));
        run(mk(0, 0,0,TP,0,0, 0,TP,4, 0,0,0,0));
        run(mk(0, 0,0,TP,0,0, 1,TCPL,0, 0,0,0,0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover %0d entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_tx_credit_gate.md
# fc_tx_credit_gate

Parametrised transmit-side flow-control gate for the PCIe TLP path. It captures the Credit Limit (CL) for the three credit classes (P, NP, Cpl) from received InitFC/UpdateFC DLLPs. It tracks Credits Consumed (CC) for every TLP accepted. It asserts `tlp_ready_o` for a pending TLP only when the PCIe modular credit check passes. It sits between the TLP arbiter and the transmit framer, and takes its FC inputs from the DLLP receive decoder.

## Interface

Parameters:

- `HDR_W`, 8: header credit counter width.
- `DATA_W`, 12: data credit counter width, in 16-byte units.

Ports:

- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `fc_valid_i`  in  1  one-cycle strobe; FC DLLP fields below are valid.
- `fc_is_init_i`  in  1  1 = InitFC, 0 = UpdateFC.
- `fc_type_i`  in  2  credit class: 00 P (MWr), 01 NP (MRd), 10 Cpl; 11 invalid.
- `fc_hdr_i`  in  HDR_W  advertised header credit limit.
- `fc_data_i`  in  DATA_W  advertised data credit limit.
- `tlp_valid_i`  in  1  TLP pending for transmit.
- `tlp_type_i`  in  2  class of the pending TLP, same encoding as `fc_type_i`.
- `tlp_data_cred_i`  in  DATA_W  data credits the TLP needs; ignored for NP.
- `tlp_ready_o`  out  1  TLP may be sent; consumed on `tlp_valid_i && tlp_ready_o`.
- `init_done_o`  out  1  all three classes initialised.
- `avail_hdr_o`  out  HDR_W  (CL_h − CC_h) mod 2^HDR_W for `tlp_type_i`.
- `avail_data_o`  out  DATA_W  (CL_d − CC_d) mod 2^DATA_W for `tlp_type_i`; 0 for NP.

## Operation

- FSM states:
  - IDLE (reset state).
  - FC_INIT: entered on the first valid InitFC.
  - ACTIVE: entered when the init mask {P, NP, Cpl} is all ones.
  - No exit from ACTIVE other than `rst`.
- InitFC handling:
  - In IDLE or FC_INIT: writes CL for its class and sets that class's mask bit.
  - A repeated InitFC for the same class overwrites its CL.
  - In ACTIVE: ignored.
- UpdateFC handling:
  - In ACTIVE: overwrites CL_h and CL_d of its class. NP writes CL_h only.
  - Outside ACTIVE: ignored.
- `fc_type_i` = 11: the FC strobe is ignored.
- Credit check for the pending TLP, all arithmetic truncated to the counter width:
  - Header: (CL_h − (CC_h + 1)) mod 2^HDR_W ≤ 2^(HDR_W−1).
  - Data: (CL_d − (CC_d + tlp_data_cred_i)) mod 2^DATA_W ≤ 2^(DATA_W−1).
- `tlp_ready_o` = ACTIVE && `tlp_type_i` ≠ 11 && header check passes && (NP || data check passes).
- On accept (`tlp_valid_i && tlp_ready_o`):
  - CC_h += 1 for the class.
  - CC_d += `tlp_data_cred_i` for P and Cpl.
  - Counters wrap modulo 2^W.
- Same-cycle UpdateFC and accept on the same class: both apply. The CL write and the CC increment land together.
- `init_done_o` = (state == ACTIVE).
- Reset values, all registers:
  - CL = 0, CC = 0, mask = 0, state = IDLE.
  - Outputs: `tlp_ready_o` = 0, `init_done_o` = 0, `avail_hdr_o` = 0, `avail_data_o` = 0.
- `rst` mid-operation discards all credit state; traffic is blocked until a full re-init.

## Timing

- An FC strobe at cycle N updates CL and the mask at the edge ending cycle N. `tlp_ready_o` and the avail outputs reflect it in cycle N+1.
- The final InitFC at cycle N gives `init_done_o` = 1 in cycle N+1.
- `tlp_ready_o` is combinational from registered CL/CC plus the current `tlp_type_i`/`tlp_data_cred_i`. It may be high while `tlp_valid_i` is low.
- An accept at cycle N is visible in CC at cycle N+1, so back-to-back accepts are supported at one TLP per cycle.
- The avail outputs are combinational from the same registers.

## Configuration

- `FC_TX_INFINITE_CREDIT_EN` defined:
  - An InitFC header value of 0 marks that class's header as infinite; a data value of 0 marks its data as infinite. The infinite flags are per class and per kind.
  - An infinite kind always passes its check.
  - CC for an infinite kind is not incremented.
  - `avail_*_o` reads all-ones for an infinite kind.
  - UpdateFC to an infinite kind is ignored.
- Not defined:
  - 0 is a literal limit, and no infinite flags exist.
  - With CL = 0 and CC = 0 the header check fails: (0 − 1) mod 256 = 255 > 128.

## Structure

- Shared package `fc_pkg`:
  - Credit class enum `fc_type_t` (P = 2'b00, NP = 2'b01, CPL = 2'b10).
  - FSM state enum (IDLE, FC_INIT, ACTIVE).
  - Default `HDR_W`/`DATA_W` localparams.
- Sub-module `fc_credit_check`:
  - Parametrised by width.
  - Holds one CL/CC pair and its infinite flag.
  - Performs the modular check.
  - Instantiated five times: P hdr, P data, NP hdr, Cpl hdr, Cpl data.

## Test plan

All scenarios use HDR_W = 8, DATA_W = 12.

- Reset, then InitFC P(4, 16), NP(2, −), Cpl(8, 32) on consecutive cycles → `tlp_ready_o` = 0 throughout; `init_done_o` = 1 the cycle after the Cpl strobe.
- Four back-to-back P TLPs of 4 data credits each → all accepted. The fifth sees `tlp_ready_o` = 0 with `avail_hdr_o` = 0 and `avail_data_o` = 0.
- UpdateFC P(6, 24) while blocked → next cycle `tlp_ready_o` = 1, `avail_hdr_o` = 2, `avail_data_o` = 8.
- Wrap-around: drive P CC_h to 0xFE with UpdateFC raising CL_h to 0x02 → four more accepts succeed (CC_h goes 0xFE→0xFF→0x00→0x01→0x02), then the gate blocks.
- Infinite credits, with the macro: InitFC Cpl(0, 0) → 1000 Cpl TLPs of 32 credits each are all accepted, avail reads 0xFF / 0xFFF. Without the macro: `tlp_ready_o` stays 0.
- Same-cycle UpdateFC P(5, 20) and accept of P(4 credits) at CC = (4, 16) → next cycle CL = (5, 20), CC = (5, 20), ready = 0. Then assert `rst` → next cycle IDLE, all outputs 0.
